// File: rtl/bp_me_pkg.sv
// Shared BedRock mem-interface types for the simple memory responder.
// Widths follow the default processor configuration.
package bp_me_pkg;

  localparam int paddr_width_p        = 40;
  localparam int cce_block_width_p    = 512;
  localparam int lce_id_width_p       = 4;
  localparam int lce_assoc_p          = 8;
  localparam int block_bytes_p        = cce_block_width_p / 8;
  localparam int block_offset_width_p = $clog2(block_bytes_p);

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    logic [lce_id_width_p-1:0]      lce_id;
    logic [$clog2(lce_assoc_p)-1:0] way_id;
  } bp_bedrock_mem_payload_s;

  typedef struct packed {
    bp_bedrock_mem_type_e      msg_type;
    logic [paddr_width_p-1:0]  addr;
    bp_bedrock_msg_size_e      size;
    bp_bedrock_mem_payload_s   payload;
  } bp_bedrock_mem_header_s;

  typedef struct packed {
    bp_bedrock_mem_header_s        header;
    logic [cce_block_width_p-1:0]  data;
  } bp_bedrock_cce_mem_msg_s;

  typedef enum logic [1:0] {
    e_ready = 2'd0,
    e_wait  = 2'd1,
    e_resp  = 2'd2
  } bp_me_state_e;

  // Byte mask within a block for a message size; sizes above a block clamp to the block.
  function automatic logic [block_offset_width_p-1:0] size_mask(input bp_bedrock_msg_size_e size);
    int lg;
    lg = (int'(size) > block_offset_width_p) ? block_offset_width_p : int'(size);
    return block_offset_width_p'((32'd1 << lg) - 32'd1);
  endfunction

endpackage

// File: rtl/bp_me_simple_mem_array.sv
// Block-wide storage: synchronous byte-masked write, asynchronous read.
// Contents are intentionally never cleared.
module bp_me_simple_mem_array #(
  parameter int els_p         = 256,
  parameter int block_width_p = 512
) (
  input  logic                          clk_i,
  input  logic                          w_v_i,
  input  logic [$clog2(els_p)-1:0]      w_idx_i,
  input  logic [block_width_p/8-1:0]    w_mask_i,
  input  logic [block_width_p-1:0]      w_data_i,
  input  logic [$clog2(els_p)-1:0]      r_idx_i,
  output logic [block_width_p-1:0]      r_data_o
);

  logic [block_width_p-1:0] mem [els_p];

  always_ff @(posedge clk_i) begin
    if (w_v_i) begin
      for (int i = 0; i < block_width_p/8; i++) begin
        if (w_mask_i[i]) begin
          mem[w_idx_i][i*8 +: 8] <= w_data_i[i*8 +: 8];
        end
      end
    end
  end

  assign r_data_o = mem[r_idx_i];

endmodule

// File: rtl/bp_me_simple_mem_responder.sv
// Single-outstanding BedRock mem responder with programmable response latency.
// Reads replicate sub-block data across the data field; writes are byte-masked.
module bp_me_simple_mem_responder
  import bp_me_pkg::*;
#(
  parameter int                       els_p        = 256,
  parameter int                       latency_p    = 4,
  parameter logic [paddr_width_p-1:0] mem_offset_p = paddr_width_p'(32'h8000_0000)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  bp_bedrock_cce_mem_msg_s  mem_cmd_i,
  input  logic                     mem_cmd_v_i,
  output logic                     mem_cmd_ready_and_o,
  output bp_bedrock_cce_mem_msg_s  mem_resp_o,
  output logic                     mem_resp_v_o,
  input  logic                     mem_resp_yumi_i,
  output logic                     error_o
);

  localparam int          idx_width_lp = $clog2(els_p);
  localparam logic [7:0]  wait_init_lp = 8'((latency_p > 0) ? latency_p - 1 : 0);

  bp_me_state_e state_r, state_n;
  logic [7:0]   cnt_r, cnt_n;

  bp_bedrock_mem_header_s         resp_header_r;
  logic [cce_block_width_p-1:0]   resp_data_r;
  logic                           error_r;

  logic                              accept;
  logic                              is_rd, is_wr;
  logic [paddr_width_p-1:0]          addr_off;
  logic [idx_width_lp-1:0]           blk_idx;
  logic [block_offset_width_p-1:0]   smask, byte_off;
  logic [block_bytes_p-1:0]          w_mask;
  logic [cce_block_width_p-1:0]      w_data, rd_block, rd_repl;

  assign mem_cmd_ready_and_o = (state_r == e_ready) & ~reset_i;
  assign mem_resp_v_o        = (state_r == e_resp) & ~reset_i;
  assign accept              = mem_cmd_v_i & mem_cmd_ready_and_o;
  assign mem_resp_o          = '{header: resp_header_r, data: resp_data_r};
  assign error_o             = error_r;

  // Addresses outside the array wrap modulo its capacity
  assign addr_off = mem_cmd_i.header.addr - mem_offset_p;
  assign blk_idx  = idx_width_lp'((addr_off >> block_offset_width_p) % paddr_width_p'(els_p));
  assign smask    = size_mask(mem_cmd_i.header.size);
  assign byte_off = addr_off[block_offset_width_p-1:0] & ~smask;

  always_comb begin
    is_rd = 1'b0;
    is_wr = 1'b0;
    case (mem_cmd_i.header.msg_type)
      e_bedrock_mem_rd, e_bedrock_mem_uc_rd: is_rd = 1'b1;
      e_bedrock_mem_wr, e_bedrock_mem_uc_wr: is_wr = 1'b1;
      default: begin
        is_rd = 1'b0;
        is_wr = 1'b0;
      end
    endcase
  end

  // Replicate the selected 2^size bytes across the whole data field
  always_comb begin
    logic [block_offset_width_p-1:0] sel;
    sel     = '0;
    rd_repl = '0;
    for (int i = 0; i < block_bytes_p; i++) begin
      sel = byte_off | (block_offset_width_p'(i) & smask);
      rd_repl[i*8 +: 8] = rd_block[{sel, 3'b000} +: 8];
    end
  end

  always_comb begin
    w_mask = '0;
    w_data = '0;
    for (int i = 0; i < block_bytes_p; i++) begin
      w_mask[i]        = ((block_offset_width_p'(i) & ~smask) == byte_off);
      w_data[i*8 +: 8] = mem_cmd_i.data[{(block_offset_width_p'(i) & smask), 3'b000} +: 8];
    end
  end

  bp_me_simple_mem_array #(
    .els_p         (els_p),
    .block_width_p (cce_block_width_p)
  ) mem_array (
    .clk_i    (clk_i),
    .w_v_i    (accept & is_wr),
    .w_idx_i  (blk_idx),
    .w_mask_i (w_mask),
    .w_data_i (w_data),
    .r_idx_i  (blk_idx),
    .r_data_o (rd_block)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_ready;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    case (state_r)
      e_ready: begin
        if (accept) begin
          if (latency_p > 0) begin
            state_n = e_wait;
            cnt_n   = wait_init_lp;
          end else begin
            state_n = e_resp;
          end
        end else begin
          state_n = e_ready;
        end
      end
      e_wait: begin
        if (cnt_r == 8'd0) begin
          state_n = e_resp;
        end else begin
          cnt_n = cnt_r - 8'd1;
        end
      end
      e_resp: begin
        if (mem_resp_yumi_i) begin
          state_n = e_ready;
        end else begin
          state_n = e_resp;
        end
      end
      default: begin
        state_n = e_ready;
        cnt_n   = '0;
      end
    endcase
  end

  // Response is captured at accept so the payload stays stable under backpressure
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      resp_header_r <= '0;
      resp_data_r   <= '0;
      error_r       <= 1'b0;
    end else if (accept) begin
      resp_header_r <= mem_cmd_i.header;
      resp_data_r   <= is_rd ? rd_repl : '0;
      error_r       <= error_r | ~(is_rd | is_wr);
    end
  end

endmodule

// File: tb/tb_bp_me_simple_mem_responder.sv
// Randomized directed bench for the simple mem responder against a byte-array model.
module tb_bp_me_simple_mem_responder;
  import bp_me_pkg::*;

  localparam int          LAT = 4;
  localparam logic [39:0] OFF = 40'h80_0000_0000 >> 8;

  logic clk, reset;
  bp_bedrock_cce_mem_msg_s cmd, resp, cmd0, resp0;
  logic cmd_v, ready, resp_v, yumi, err;
  logic cmd0_v, ready0, resp0_v, yumi0, err0;

  int checks = 0;
  int errors = 0;
  logic [7:0] model [0:16383];
  logic exp_err = 1'b0;

  bp_me_simple_mem_responder #(.els_p(256), .latency_p(LAT)) dut (
    .clk_i(clk), .reset_i(reset), .mem_cmd_i(cmd), .mem_cmd_v_i(cmd_v),
    .mem_cmd_ready_and_o(ready), .mem_resp_o(resp), .mem_resp_v_o(resp_v),
    .mem_resp_yumi_i(yumi), .error_o(err));

  bp_me_simple_mem_responder #(.els_p(256), .latency_p(0)) dut0 (
    .clk_i(clk), .reset_i(reset), .mem_cmd_i(cmd0), .mem_cmd_v_i(cmd0_v),
    .mem_cmd_ready_and_o(ready0), .mem_resp_o(resp0), .mem_resp_v_o(resp0_v),
    .mem_resp_yumi_i(yumi0), .error_o(err0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rand_blk();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Model: memory is a flat byte array, 64 bytes per block, 256 blocks, wrapping.
  function automatic int model_base(input logic [39:0] a, input int nb);
    logic [39:0] d;
    int idx, off;
    d   = a - OFF;
    idx = int'((d / 40'd64) % 40'd256);
    off = (int'(d % 40'd64) / nb) * nb;
    return idx * 64 + off;
  endfunction

  function automatic logic [511:0] model_rd(input logic [39:0] a, input int sz);
    logic [511:0] r;
    int nb, base;
    nb   = 1 << ((sz > 6) ? 6 : sz);
    base = model_base(a, nb);
    for (int i = 0; i < 64; i++) r[i*8 +: 8] = model[base + (i % nb)];
    return r;
  endfunction

  task automatic model_wr(input logic [39:0] a, input int sz, input logic [511:0] d);
    int nb, base;
    nb   = 1 << ((sz > 6) ? 6 : sz);
    base = model_base(a, nb);
    for (int j = 0; j < nb; j++) model[base + j] = d[j*8 +: 8];
  endtask

  // One full transaction on the latency-LAT instance; entered and left just after a negedge.
  task automatic txn(input bp_bedrock_mem_type_e mt, input logic [39:0] addr,
                     input bp_bedrock_msg_size_e sz, input logic [511:0] data,
                     input int hold, input string tag, output bp_bedrock_cce_mem_msg_s got);
    bp_bedrock_cce_mem_msg_s c, e;
    int n;
    logic ok;
    c.header.msg_type       = mt;
    c.header.addr           = addr;
    c.header.size           = sz;
    c.header.payload.lce_id = 4'($urandom);
    c.header.payload.way_id = 3'($urandom);
    c.data                  = data;
    e.header = c.header;
    e.data   = '0;
    if (mt == e_bedrock_mem_rd || mt == e_bedrock_mem_uc_rd) e.data = model_rd(addr, int'(sz));
    else if (mt == e_bedrock_mem_wr || mt == e_bedrock_mem_uc_wr) model_wr(addr, int'(sz), data);
    else exp_err = 1'b1;

    cmd = c;
    cmd_v = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk({tag, " ready"}, ready, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_v = 1'b0;
    cmd.data = rand_blk();
    n = 1;
    ok = 1'b1;
    while (resp_v !== 1'b1 && n < 300) begin
      if (ready !== 1'b0) ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, n, LAT + 1);
    chk({tag, " wait_ready"}, ok, 1);
    ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      if (resp !== e || ready !== 1'b0 || resp_v !== 1'b1) ok = 1'b0;
      @(negedge clk);
    end
    chk({tag, " hold"}, ok, 1);
    chk({tag, " resp"}, resp, e);
    got = resp;
    yumi = 1'b1;
    @(posedge clk);
    @(negedge clk);
    yumi = 1'b0;
    chk({tag, " ready_after"}, {ready, resp_v}, 2'b10);
    chk({tag, " error"}, err, exp_err);
  endtask

  initial begin
    bp_bedrock_cce_mem_msg_s got;
    bp_bedrock_mem_type_e mt;
    bp_bedrock_msg_size_e sz;
    logic [511:0] expd;
    logic [39:0] a;
    logic ok;

    reset = 1'b1;
    cmd = '0; cmd_v = 1'b0; yumi = 1'b0;
    cmd0 = '0; cmd0_v = 1'b0; yumi0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset outs", {ready, resp_v, err, resp}, '0);
    chk("reset outs0", {ready0, resp0_v, err0, resp0}, '0);
    reset = 1'b0;
    #1;
    chk("ready after reset", {ready, ready0}, 2'b11);

    for (int b = 0; b < 256; b++)
      txn(e_bedrock_mem_wr, OFF + 40'(b * 64), e_bedrock_msg_size_64, '0, 0, "prezero", got);

    txn(e_bedrock_mem_uc_wr, 40'h80_0000_08, e_bedrock_msg_size_8,
        {448'h0, 64'hDEAD_BEEF_CAFE_F00D}, 0, "blkwr", got);
    chk("blkwr data", got.data, 0);
    txn(e_bedrock_mem_rd, 40'h80_0000_00, e_bedrock_msg_size_64, '0, 0, "blkrd", got);
    expd = '0;
    expd[127:64] = 64'hDEAD_BEEF_CAFE_F00D;
    chk("blkrd data", got.data, expd);

    txn(e_bedrock_mem_rd, 40'h80_0000_00, e_bedrock_msg_size_64, '0, 10, "backpressure", got);

    txn(e_bedrock_mem_uc_wr, 40'h80_0000_40, e_bedrock_msg_size_4, {480'h0, 32'h1122_3344}, 0, "subwr", got);
    txn(e_bedrock_mem_uc_rd, 40'h80_0000_42, e_bedrock_msg_size_1, '0, 0, "subrd", got);
    chk("subrd data", got.data, {64{8'h22}});

    txn(e_bedrock_mem_wr, 40'h80_0040_00, e_bedrock_msg_size_8, {448'h0, 64'h0123_4567_89AB_CDEF}, 0, "wrapwr", got);
    txn(e_bedrock_mem_rd, 40'h80_0000_00, e_bedrock_msg_size_8, '0, 0, "wraprd", got);
    chk("wraprd data", got.data, {8{64'h0123_4567_89AB_CDEF}});

    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 3))
        0: mt = e_bedrock_mem_rd;
        1: mt = e_bedrock_mem_uc_rd;
        2: mt = e_bedrock_mem_wr;
        default: mt = e_bedrock_mem_uc_wr;
      endcase
      sz = bp_bedrock_msg_size_e'($urandom_range(0, 6));
      a  = 40'h7F_FFFF_F000 + 40'($urandom_range(0, 32'h6000));
      txn(mt, a, sz, rand_blk(), $urandom_range(0, 3), "rand", got);
    end

    txn(e_bedrock_mem_amo, 40'h80_0000_00, e_bedrock_msg_size_8, rand_blk(), 0, "amo", got);
    chk("amo data", got.data, 0);
    txn(e_bedrock_mem_rd, 40'h80_0000_40, e_bedrock_msg_size_4, '0, 0, "after_amo", got);

    // Reset while a read is waiting: the response must never appear
    cmd.header.msg_type = e_bedrock_mem_rd;
    cmd.header.addr     = 40'h80_0000_00;
    cmd.header.size     = e_bedrock_msg_size_64;
    cmd_v = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_v = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("midreset outs", {ready, resp_v}, 2'b00);
    reset = 1'b0;
    exp_err = 1'b0;
    #1;
    chk("postreset ready", ready, 1);
    chk("postreset err", err, exp_err);
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_v !== 1'b0) ok = 1'b0;
    end
    chk("postreset no resp", ok, 1);

    // Zero-latency instance
    cmd0.header.msg_type = e_bedrock_mem_uc_wr;
    cmd0.header.addr     = 40'h80_0001_00;
    cmd0.header.size     = e_bedrock_msg_size_8;
    cmd0.header.payload  = '0;
    cmd0.data            = {448'h0, 64'hA5A5_0F0F_1234_5678};
    cmd0_v = 1'b1;
    chk("lat0 ready", ready0, 1);
    @(posedge clk);
    @(negedge clk);
    cmd0_v = 1'b0;
    chk("lat0 v at N+1", {resp0_v, ready0}, 2'b10);
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ready0 !== 1'b0 || resp0_v !== 1'b1) ok = 1'b0;
    end
    chk("lat0 hold", ok, 1);
    yumi0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    yumi0 = 1'b0;
    chk("lat0 ready after yumi", {ready0, resp0_v}, 2'b10);
    cmd0.header.msg_type = e_bedrock_mem_rd;
    cmd0_v = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd0_v = 1'b0;
    chk("lat0 rd v", resp0_v, 1);
    chk("lat0 rd resp", resp0, {cmd0.header, {8{64'hA5A5_0F0F_1234_5678}}});
    yumi0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    yumi0 = 1'b0;
    chk("lat0 err", err0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
